// File: rtl/mcycle_sequencer_if.sv
// Core <-> multi-cycle MUL/DIV engine request/result bundle.
// The core drives the request side and holds Start until Busy falls.
interface mcycle_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy
  );
endinterface

// File: rtl/mcycle_sequencer.sv
// Iterative unsigned shift-add multiplier / restoring divider on one shared acc_hi/acc_lo pair.
// Busy is high for WIDTH+1 cycles (Start cycle + WIDTH iterations) and stalls the core; results held until next op.
module mcycle_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  mcycle_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic             op_q;
  logic [WIDTH-1:0] opnd_q;       // multiplicand for MUL, divisor for DIV
  logic [WIDTH-1:0] acc_hi;       // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;       // multiplier shifting out / dividend becoming quotient
  logic [WIDTH-1:0] result1_q, result2_q;
  logic             busy;
  logic             last_iter;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  assign last_iter = (count == CW'(WIDTH - 1));

  // One iteration of either algorithm; carry of the add lands in acc_hi MSB on the shift.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (op_q) begin
      iter_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      iter_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.Start) state_nxt = COMPUTING;
      COMPUTING: if (last_iter) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    case (state)
      IDLE:      busy = bus.Start;
      COMPUTING: busy = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count     <= '0;
      op_q      <= 1'b0;
      opnd_q    <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      result1_q <= '0;
      result2_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            op_q   <= bus.MCycleOp;
            opnd_q <= bus.MCycleOp ? bus.Operand2 : bus.Operand1;
            acc_lo <= bus.MCycleOp ? bus.Operand1 : bus.Operand2;
            acc_hi <= '0;
            count  <= '0;
          end
        end
        COMPUTING: begin
          acc_hi <= iter_hi;
          acc_lo <= iter_lo;
          count  <= count + 1'b1;
          if (last_iter) begin
            result1_q <= iter_lo;
            result2_q <= iter_hi;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Result1 = result1_q;
  assign bus.Result2 = result2_q;
  assign bus.Busy    = busy;
endmodule

// File: tb/tb_mcycle_sequencer.sv
// Directed checks of the MUL/DIV sequencer: latency, results, operand hold, DONE handling, async reset.
module tb_mcycle_sequencer;
  logic CLK = 1'b0;
  logic RESET;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  mcycle_sequencer_if #(.WIDTH(32)) bus();
  mcycle_sequencer #(.WIDTH(32)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  // Raises Start with the given op and counts Busy-high cycles; returns in DONE with Start still high.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output int busy_cnt);
    @(posedge CLK); #1;
    bus.Start = 1'b1; bus.MCycleOp = op; bus.Operand1 = a; bus.Operand2 = b;
    #1;
    busy_cnt = 0;
    for (int i = 0; i < 100 && bus.Busy === 1'b1; i++) begin
      busy_cnt++;
      @(posedge CLK); #1;
      if (scramble) begin
        bus.MCycleOp = 1'($urandom);
        bus.Operand1 = $urandom;
        bus.Operand2 = $urandom;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; bus.Start = 1'b0; bus.MCycleOp = 1'b0; bus.Operand1 = '0; bus.Operand2 = '0;
    #12;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    n_cmp++; if (bus.Result1 !== 32'h0) begin n_err++; $display("FAIL reset_r1: got %h want 0", bus.Result1); end
    n_cmp++; if (bus.Result2 !== 32'h0) begin n_err++; $display("FAIL reset_r2: got %h want 0", bus.Result2); end
    bus.Start = 1'b1; #1;
    n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL reset_busy_start: got %b want 1", bus.Busy); end
    bus.Start = 1'b0;
    @(negedge CLK); RESET = 1'b0;
  endtask

  task automatic test_mul();
    int bc;
    run_op(1'b0, 32'h0000_05DB, 32'h0000_00CC, 1'b0, bc);
    n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL mul_latency: got %0d want 33", bc); end
    bus.Start = 1'b0;
    n_cmp++; if (bus.Result1 !== 32'h0004_AA84) begin n_err++; $display("FAIL mul_r1: got %h want 0004aa84", bus.Result1); end
    n_cmp++; if (bus.Result2 !== 32'h0) begin n_err++; $display("FAIL mul_r2: got %h want 0", bus.Result2); end
  endtask

  task automatic test_div();
    int bc;
    run_op(1'b1, 32'h0000_05DB, 32'h0000_00BB, 1'b0, bc);
    n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL div_latency: got %0d want 33", bc); end
    bus.Start = 1'b0;
    n_cmp++; if (bus.Result1 !== 32'h8) begin n_err++; $display("FAIL div_quo: got %h want 8", bus.Result1); end
    n_cmp++; if (bus.Result2 !== 32'h3) begin n_err++; $display("FAIL div_rem: got %h want 3", bus.Result2); end
  endtask

  task automatic test_extremes();
    int bc;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, bc);
    bus.Start = 1'b0;
    n_cmp++; if (bus.Result1 !== 32'h1) begin n_err++; $display("FAIL max_mul_r1: got %h want 1", bus.Result1); end
    n_cmp++; if (bus.Result2 !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL max_mul_r2: got %h want fffffffe", bus.Result2); end
    run_op(1'b1, 32'h7, 32'h0, 1'b0, bc);
    bus.Start = 1'b0;
    n_cmp++; if (bus.Result1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_quo: got %h want ffffffff", bus.Result1); end
    n_cmp++; if (bus.Result2 !== 32'h7) begin n_err++; $display("FAIL div0_rem: got %h want 7", bus.Result2); end
  endtask

  task automatic test_operand_hold();
    int bc;
    run_op(1'b0, 32'h0000_05DB, 32'h0000_00CC, 1'b1, bc);
    bus.Start = 1'b0;
    n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL hold_latency: got %0d want 33", bc); end
    n_cmp++; if (bus.Result1 !== 32'h0004_AA84) begin n_err++; $display("FAIL hold_mul_r1: got %h want 0004aa84", bus.Result1); end
    run_op(1'b1, 32'd1000, 32'd7, 1'b1, bc);
    bus.Start = 1'b0;
    n_cmp++; if (bus.Result1 !== 32'd142) begin n_err++; $display("FAIL hold_div_quo: got %0d want 142", bus.Result1); end
    n_cmp++; if (bus.Result2 !== 32'd6) begin n_err++; $display("FAIL hold_div_rem: got %0d want 6", bus.Result2); end
  endtask

  task automatic test_start_through_done();
    int bc;
    bit restarted;
    run_op(1'b1, 32'h0000_05DB, 32'h0000_00BB, 1'b0, bc);
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL done_busy_with_start: got %b want 0", bus.Busy); end
    bus.Start = 1'b0;
    bus.MCycleOp = 1'b0; bus.Operand1 = 32'd9; bus.Operand2 = 32'd9;
    restarted = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (bus.Busy !== 1'b0) restarted = 1'b1;
    end
    n_cmp++; if (restarted !== 1'b0) begin n_err++; $display("FAIL done_no_restart: got %b want 0", restarted); end
    n_cmp++; if (bus.Result1 !== 32'h8) begin n_err++; $display("FAIL done_hold_quo: got %h want 8", bus.Result1); end
  endtask

  task automatic test_back_to_back();
    int bc;
    run_op(1'b0, 32'd3, 32'd5, 1'b0, bc);
    n_cmp++; if (bus.Result1 !== 32'd15) begin n_err++; $display("FAIL b2b_first: got %0d want 15", bus.Result1); end
    // Start still high in DONE; the next IDLE cycle must launch immediately
    run_op(1'b1, 32'd100, 32'd7, 1'b0, bc);
    bus.Start = 1'b0;
    n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL b2b_latency: got %0d want 33", bc); end
    n_cmp++; if (bus.Result1 !== 32'd14) begin n_err++; $display("FAIL b2b_quo: got %0d want 14", bus.Result1); end
    n_cmp++; if (bus.Result2 !== 32'd2) begin n_err++; $display("FAIL b2b_rem: got %0d want 2", bus.Result2); end
  endtask

  task automatic test_async_reset();
    int bc;
    @(posedge CLK); #1;
    bus.Start = 1'b1; bus.MCycleOp = 1'b0; bus.Operand1 = 32'h0000_05DB; bus.Operand2 = 32'h0000_00CC;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL arst_busy_before: got %b want 1", bus.Busy); end
    RESET = 1'b1; #1;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", bus.Busy); end
    n_cmp++; if (bus.Result1 !== 32'h0) begin n_err++; $display("FAIL arst_r1: got %h want 0", bus.Result1); end
    n_cmp++; if (bus.Result2 !== 32'h0) begin n_err++; $display("FAIL arst_r2: got %h want 0", bus.Result2); end
    @(negedge CLK); RESET = 1'b0;
    run_op(1'b0, 32'd3, 32'd5, 1'b0, bc);
    bus.Start = 1'b0;
    n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL arst_new_latency: got %0d want 33", bc); end
    n_cmp++; if (bus.Result1 !== 32'hF) begin n_err++; $display("FAIL arst_new_r1: got %h want f", bus.Result1); end
    n_cmp++; if (bus.Result2 !== 32'h0) begin n_err++; $display("FAIL arst_new_r2: got %h want 0", bus.Result2); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_extremes();
    test_operand_hold();
    test_start_through_done();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
